// File: rtl/udp_echo_responder.sv
// UDP echo endpoint: swaps addresses/ports of datagrams addressed to LOCAL_PORT and
// streams the payload straight back; other datagrams are drained and counted.
module udp_echo_responder #(
  parameter logic [15:0]  LOCAL_PORT  = 16'd7,
  parameter logic [7:0]   TTL         = 8'd64,
  parameter int unsigned  COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // RX header
  input  logic                   rx_hdr_valid_i,
  output logic                   rx_hdr_ready_o,
  input  logic [31:0]            rx_ip_source_ip_i,
  input  logic [31:0]            rx_ip_dest_ip_i,
  input  logic [15:0]            rx_source_port_i,
  input  logic [15:0]            rx_dest_port_i,
  input  logic [15:0]            rx_length_i,
  input  logic [15:0]            rx_checksum_i,
  // RX payload
  input  logic [7:0]             rx_tdata_i,
  input  logic                   rx_tkeep_i,
  input  logic                   rx_tvalid_i,
  output logic                   rx_tready_o,
  input  logic                   rx_tlast_i,
  input  logic                   rx_tuser_i,
  // TX header
  output logic                   tx_hdr_valid_o,
  input  logic                   tx_hdr_ready_i,
  output logic [5:0]             tx_ip_dscp_o,
  output logic [1:0]             tx_ip_ecn_o,
  output logic [7:0]             tx_ip_ttl_o,
  output logic [31:0]            tx_ip_source_ip_o,
  output logic [31:0]            tx_ip_dest_ip_o,
  output logic [15:0]            tx_source_port_o,
  output logic [15:0]            tx_dest_port_o,
  output logic [15:0]            tx_length_o,
  output logic [15:0]            tx_checksum_o,
  // TX payload
  output logic [7:0]             tx_tdata_o,
  output logic                   tx_tkeep_o,
  output logic                   tx_tvalid_o,
  input  logic                   tx_tready_i,
  output logic                   tx_tlast_o,
  output logic                   tx_tuser_o,
  // Statistics
  output logic [COUNT_WIDTH-1:0] echo_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StDrop} state_e;

  state_e                 state_q, state_d;
  logic                   active_q;
  logic                   latch_hdr, echo_inc, drop_inc;
  logic [31:0]            src_ip_q, dst_ip_q;
  logic [15:0]            src_port_q, dst_port_q, length_q;
  logic [COUNT_WIDTH-1:0] echo_count_q, drop_count_q;

  // Incoming checksum is discarded: the TX checksum is offloaded downstream.
  logic unused_checksum;
  assign unused_checksum = ^rx_checksum_i;

  always_comb begin
    state_d        = state_q;
    rx_hdr_ready_o = 1'b0;
    rx_tready_o    = 1'b0;
    tx_hdr_valid_o = 1'b0;
    tx_tvalid_o    = 1'b0;
    latch_hdr      = 1'b0;
    echo_inc       = 1'b0;
    drop_inc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // active_q holds readies low until the first edge after reset release.
        rx_hdr_ready_o = active_q;
        if (rx_hdr_valid_i && active_q) begin
          if (rx_dest_port_i == LOCAL_PORT) begin
            latch_hdr = 1'b1;
            state_d   = StHdr;
          end else begin
            state_d   = StDrop;
          end
        end
      end
      StHdr: begin
        tx_hdr_valid_o = 1'b1;
        if (tx_hdr_ready_i) state_d = StPayload;
      end
      StPayload: begin
        tx_tvalid_o = rx_tvalid_i;
        rx_tready_o = tx_tready_i;
        if (rx_tvalid_i && tx_tready_i && rx_tlast_i) begin
          echo_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      StDrop: begin
        rx_tready_o = 1'b1;
        if (rx_tvalid_i && rx_tlast_i) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      active_q     <= 1'b0;
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      src_port_q   <= '0;
      dst_port_q   <= '0;
      length_q     <= '0;
      echo_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      if (latch_hdr) begin
        // Swap at latch time so the TX fields come straight from flops.
        src_ip_q   <= rx_ip_dest_ip_i;
        dst_ip_q   <= rx_ip_source_ip_i;
        src_port_q <= rx_dest_port_i;
        dst_port_q <= rx_source_port_i;
        length_q   <= rx_length_i;
      end
      if (echo_inc) echo_count_q <= echo_count_q + COUNT_WIDTH'(1);
      if (drop_inc) drop_count_q <= drop_count_q + COUNT_WIDTH'(1);
    end
  end

  assign tx_ip_dscp_o      = 6'd0;
  assign tx_ip_ecn_o       = 2'd0;
  assign tx_ip_ttl_o       = TTL;
  assign tx_ip_source_ip_o = src_ip_q;
  assign tx_ip_dest_ip_o   = dst_ip_q;
  assign tx_source_port_o  = src_port_q;
  assign tx_dest_port_o    = dst_port_q;
  assign tx_length_o       = length_q;
  assign tx_checksum_o     = 16'd0;

  assign tx_tdata_o = rx_tdata_i;
  assign tx_tkeep_o = rx_tkeep_i;
  assign tx_tlast_o = rx_tlast_i;
  assign tx_tuser_o = rx_tuser_i;

  assign echo_count = echo_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed bench for udp_echo_responder: echo, drop, backpressure, tuser, reset, back-to-back.
module tb_udp_echo_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_hdr_valid, rx_hdr_ready;
  logic [31:0] rx_ip_source_ip, rx_ip_dest_ip;
  logic [15:0] rx_source_port, rx_dest_port, rx_length, rx_checksum;
  logic [7:0]  rx_tdata;
  logic        rx_tkeep, rx_tvalid, rx_tready, rx_tlast, rx_tuser;
  logic        tx_hdr_valid, tx_hdr_ready;
  logic [5:0]  tx_ip_dscp;
  logic [1:0]  tx_ip_ecn;
  logic [7:0]  tx_ip_ttl;
  logic [31:0] tx_ip_source_ip, tx_ip_dest_ip;
  logic [15:0] tx_source_port, tx_dest_port, tx_length, tx_checksum;
  logic [7:0]  tx_tdata;
  logic        tx_tkeep, tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [31:0] echo_count, drop_count;

  udp_echo_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rx_hdr_valid_i   (rx_hdr_valid),
    .rx_hdr_ready_o   (rx_hdr_ready),
    .rx_ip_source_ip_i(rx_ip_source_ip),
    .rx_ip_dest_ip_i  (rx_ip_dest_ip),
    .rx_source_port_i (rx_source_port),
    .rx_dest_port_i   (rx_dest_port),
    .rx_length_i      (rx_length),
    .rx_checksum_i    (rx_checksum),
    .rx_tdata_i       (rx_tdata),
    .rx_tkeep_i       (rx_tkeep),
    .rx_tvalid_i      (rx_tvalid),
    .rx_tready_o      (rx_tready),
    .rx_tlast_i       (rx_tlast),
    .rx_tuser_i       (rx_tuser),
    .tx_hdr_valid_o   (tx_hdr_valid),
    .tx_hdr_ready_i   (tx_hdr_ready),
    .tx_ip_dscp_o     (tx_ip_dscp),
    .tx_ip_ecn_o      (tx_ip_ecn),
    .tx_ip_ttl_o      (tx_ip_ttl),
    .tx_ip_source_ip_o(tx_ip_source_ip),
    .tx_ip_dest_ip_o  (tx_ip_dest_ip),
    .tx_source_port_o (tx_source_port),
    .tx_dest_port_o   (tx_dest_port),
    .tx_length_o      (tx_length),
    .tx_checksum_o    (tx_checksum),
    .tx_tdata_o       (tx_tdata),
    .tx_tkeep_o       (tx_tkeep),
    .tx_tvalid_o      (tx_tvalid),
    .tx_tready_i      (tx_tready),
    .tx_tlast_o       (tx_tlast),
    .tx_tuser_o       (tx_tuser),
    .echo_count       (echo_count),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int waits;
  int tx_act, bad_consume, overlap;
  bit in_drop, in_flight;
  logic [7:0]  pay [16];
  logic [9:0]  tx_q[$], exp_q[$];   // {tuser, tlast, tdata}
  logic [15:0] hq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frames(input string tag);
    check_eq({tag, "_beats"}, 64'(tx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check_eq(tag, 64'(tx_q[i]), 64'(exp_q[i]));
  endtask

  // Samples settled values after the drivers have updated on the falling edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset_n) begin
      in_flight = 1'b0;
    end else begin
      if (tx_tvalid && tx_tready) tx_q.push_back({tx_tuser, tx_tlast, tx_tdata});
      if (tx_hdr_valid && tx_hdr_ready) hq.push_back(tx_dest_port);
      if (tx_hdr_valid || tx_tvalid) tx_act++;
      if (rx_tvalid && rx_tready && !tx_tready && !in_drop) bad_consume++;
      if (rx_hdr_valid && rx_hdr_ready) begin
        if (in_flight) overlap++;
        in_flight = 1'b1;
      end
      if (rx_tvalid && rx_tready && rx_tlast) in_flight = 1'b0;
    end
  end

  task automatic send_hdr(input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
    int w;
    rx_hdr_valid = 1'b1;
    rx_ip_source_ip = sip;
    rx_ip_dest_ip = dip;
    rx_source_port = sp;
    rx_dest_port = dp;
    rx_length = len;
    rx_checksum = 16'hBEEF;
    #1;
    w = 0;
    while (!rx_hdr_ready && w < 60) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_eq("rx_hdr_accept", 64'(rx_hdr_ready), 64'd1);
    @(negedge clk);
    rx_hdr_valid = 1'b0;
  endtask

  // Sends beats 0..stop-1 of an n-beat payload from pay[]; toggle flips tx_tready every cycle.
  task automatic send_payload(input int n, input int stop, input logic usr, input bit toggle);
    int w;
    for (int i = 0; i < stop; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata = pay[i];
      rx_tlast = (i == n - 1);
      rx_tuser = usr && (i == n - 1);
      #1;
      w = 0;
      while (!rx_tready && w < 60) begin
        @(negedge clk);
        if (toggle) tx_tready = !tx_tready;
        #1;
        w++;
      end
      waits += w;
      check_eq("rx_beat_accept", 64'(rx_tready), 64'd1);
      @(negedge clk);
      if (toggle) tx_tready = !tx_tready;
    end
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    rx_tuser = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rx_hdr_valid = 1'b0; rx_ip_source_ip = '0; rx_ip_dest_ip = '0;
    rx_source_port = '0; rx_dest_port = '0; rx_length = '0; rx_checksum = '0;
    rx_tdata = '0; rx_tkeep = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    tx_hdr_ready = 1'b1; tx_tready = 1'b1;
    tx_act = 0; bad_consume = 0; overlap = 0; in_drop = 1'b0; in_flight = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rx_hdr_ready", 64'(rx_hdr_ready), 64'd0);
    check_eq("rst_tx_hdr_valid", 64'(tx_hdr_valid), 64'd0);
    check_eq("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check_eq("rst_rx_tready", 64'(rx_tready), 64'd0);
    check_eq("rst_tx_dest_port", 64'(tx_dest_port), 64'd0);
    check_eq("rst_echo_count", 64'(echo_count), 64'd0);
    check_eq("rst_drop_count", 64'(drop_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("idle_rx_hdr_ready", 64'(rx_hdr_ready), 64'd1);

    // Echo without backpressure
    tx_q.delete();
    exp_q = '{10'h001, 10'h002, 10'h003, 10'h104};
    send_hdr(32'h0A00_0002, 32'h0A00_0001, 16'd5000, 16'd7, 16'd12);
    #1;
    check_eq("t1_hdr_valid_lat1", 64'(tx_hdr_valid), 64'd1);
    check_eq("t1_src_ip", 64'(tx_ip_source_ip), 64'h0A00_0001);
    check_eq("t1_dst_ip", 64'(tx_ip_dest_ip), 64'h0A00_0002);
    check_eq("t1_src_port", 64'(tx_source_port), 64'd7);
    check_eq("t1_dst_port", 64'(tx_dest_port), 64'd5000);
    check_eq("t1_length", 64'(tx_length), 64'd12);
    check_eq("t1_ttl", 64'(tx_ip_ttl), 64'd64);
    check_eq("t1_checksum", 64'(tx_checksum), 64'd0);
    check_eq("t1_dscp_ecn", 64'({tx_ip_dscp, tx_ip_ecn}), 64'd0);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    send_payload(4, 4, 1'b0, 1'b0);
    check_frames("t1_tx_beat");
    check_eq("t1_echo_count", 64'(echo_count), 64'd1);

    // Port mismatch is drained, then a port-7 datagram still echoes
    tx_q.delete();
    exp_q.delete();
    tx_act = 0;
    waits = 0;
    in_drop = 1'b1;
    send_hdr(32'h0A00_0002, 32'h0A00_0001, 16'd5000, 16'd9, 16'd11);
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    send_payload(3, 3, 1'b0, 1'b0);
    in_drop = 1'b0;
    #1;
    check_eq("t2_tx_activity", 64'(tx_act), 64'd0);
    check_eq("t2_rx_tready_waits", 64'(waits), 64'd0);
    check_eq("t2_drop_count", 64'(drop_count), 64'd1);
    check_eq("t2_echo_count", 64'(echo_count), 64'd1);
    check_frames("t2_tx_beat");
    exp_q = '{10'h1AB};
    send_hdr(32'h0A00_0003, 32'h0A00_0001, 16'd6000, 16'd7, 16'd9);
    pay[0] = 8'hAB;
    send_payload(1, 1, 1'b0, 1'b0);
    check_frames("t2_follow_beat");
    check_eq("t2_echo_after", 64'(echo_count), 64'd2);

    // Backpressure on header and payload
    tx_q.delete();
    bad_consume = 0;
    waits = 0;
    tx_hdr_ready = 1'b0;
    send_hdr(32'hC0A8_0105, 32'h0A00_0001, 16'd1234, 16'd7, 16'd16);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("t3_hdr_valid_hold", 64'(tx_hdr_valid), 64'd1);
      check_eq("t3_dst_ip_hold", 64'(tx_ip_dest_ip), 64'hC0A8_0105);
      check_eq("t3_dst_port_hold", 64'(tx_dest_port), 64'd1234);
      check_eq("t3_rx_tready_in_hdr", 64'(rx_tready), 64'd0);
      @(negedge clk);
    end
    tx_hdr_ready = 1'b1;
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      pay[i] = 8'h30 + 8'(i);
      exp_q.push_back({1'b0, (i == 7), 8'h30 + 8'(i)});
    end
    send_payload(8, 8, 1'b0, 1'b1);
    tx_tready = 1'b1;
    check_frames("t3_tx_beat");
    check_eq("t3_bp_waits", 64'(waits), 64'd7);
    check_eq("t3_bad_consume", 64'(bad_consume), 64'd0);
    check_eq("t3_echo_count", 64'(echo_count), 64'd3);

    // Single beat with tuser
    tx_q.delete();
    exp_q = '{10'h3A5};
    send_hdr(32'h0A00_0004, 32'h0A00_0001, 16'd4000, 16'd7, 16'd9);
    pay[0] = 8'hA5;
    send_payload(1, 1, 1'b1, 1'b0);
    #1;
    check_frames("t4_tx_beat");
    check_eq("t4_echo_count", 64'(echo_count), 64'd4);
    check_eq("t4_idle_hdr_ready", 64'(rx_hdr_ready), 64'd1);

    // Reset mid-payload
    tx_q.delete();
    send_hdr(32'h0A00_0005, 32'h0A00_0001, 16'd4100, 16'd7, 16'd14);
    for (int i = 0; i < 6; i++) pay[i] = 8'h50 + 8'(i);
    send_payload(6, 2, 1'b0, 1'b0);
    rx_tvalid = 1'b1;
    rx_tdata = pay[2];
    #1;
    check_eq("t5_tvalid_before_rst", 64'(tx_tvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check_eq("t5_rst_tx_hdr_valid", 64'(tx_hdr_valid), 64'd0);
    check_eq("t5_rst_rx_tready", 64'(rx_tready), 64'd0);
    check_eq("t5_rst_rx_hdr_ready", 64'(rx_hdr_ready), 64'd0);
    check_eq("t5_rst_echo_count", 64'(echo_count), 64'd0);
    check_eq("t5_rst_drop_count", 64'(drop_count), 64'd0);
    check_eq("t5_truncated_beats", 64'(tx_q.size()), 64'd2);
    @(negedge clk);
    rx_tvalid = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tx_q.delete();
    exp_q = '{10'h061, 10'h062, 10'h163};
    send_hdr(32'h0A00_0006, 32'h0A00_0001, 16'd4200, 16'd7, 16'd11);
    #1;
    check_eq("t5_post_src_port", 64'(tx_source_port), 64'd7);
    check_eq("t5_post_dst_port", 64'(tx_dest_port), 64'd4200);
    pay[0] = 8'h61; pay[1] = 8'h62; pay[2] = 8'h63;
    send_payload(3, 3, 1'b0, 1'b0);
    check_frames("t5_post_beat");
    check_eq("t5_post_echo_count", 64'(echo_count), 64'd1);

    // Back-to-back headers presented continuously
    tx_q.delete();
    hq.delete();
    overlap = 0;
    exp_q = '{10'h011, 10'h112, 10'h021, 10'h022, 10'h123, 10'h131};
    fork
      begin
        send_hdr(32'h0A00_0007, 32'h0A00_0001, 16'd100, 16'd7, 16'd10);
        send_hdr(32'h0A00_0008, 32'h0A00_0001, 16'd200, 16'd7, 16'd11);
        send_hdr(32'h0A00_0009, 32'h0A00_0001, 16'd300, 16'd7, 16'd9);
      end
      begin
        pay[0] = 8'h11; pay[1] = 8'h12;
        send_payload(2, 2, 1'b0, 1'b0);
        pay[0] = 8'h21; pay[1] = 8'h22; pay[2] = 8'h23;
        send_payload(3, 3, 1'b0, 1'b0);
        pay[0] = 8'h31;
        send_payload(1, 1, 1'b0, 1'b0);
      end
    join
    #1;
    check_frames("t6_tx_beat");
    check_eq("t6_overlap", 64'(overlap), 64'd0);
    check_eq("t6_hdr_count", 64'(hq.size()), 64'd3);
    if (hq.size() == 3) begin
      check_eq("t6_hdr0_dst_port", 64'(hq[0]), 64'd100);
      check_eq("t6_hdr1_dst_port", 64'(hq[1]), 64'd200);
      check_eq("t6_hdr2_dst_port", 64'(hq[2]), 64'd300);
    end
    check_eq("t6_echo_count", 64'(echo_count), 64'd4);
    check_eq("t6_drop_count", 64'(drop_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
